// File: rtl/reg_seq_pkg.sv
// Shared types and constants for the reg_file command sequencer.
// Optional feature macro: REG_SEQ_SWAP_EN (enables the SWP command).
package reg_seq_pkg;

    // Command opcodes; encodings 5..7 are illegal.
    typedef enum logic [2:0] {
        OP_LDA = 3'd0,
        OP_STA = 3'd1,
        OP_RDR = 3'd2,
        OP_SWP = 3'd3,
        OP_CLR = 3'd4
    } op_e;

    // Sequencer states. SWP_A only exists when swap support is built in.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
`ifdef REG_SEQ_SWAP_EN
        ST_SWP_A = 3'd2,
`endif
        ST_CLR_Z = 3'd3,
        ST_CLR_S = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Accept-to-response latency of the single-step commands.
    localparam int RSP_LAT_SIMPLE = 2;

    // True when the opcode is implemented in this build.
    function automatic logic op_legal(input logic [2:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_LDA, OP_STA, OP_RDR, OP_CLR: legal = 1'b1;
`ifdef REG_SEQ_SWAP_EN
            OP_SWP:                         legal = 1'b1;
`endif
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/reg_seq_sweep_cnt.sv
// Register-address sweep counter for the CLR command.
// Clears to 0, increments one step per enabled cycle, and saturates at
// NUM_REG-1 so the sweep never wraps back to address 0.
module reg_seq_sweep_cnt #(
    parameter int NUM_REG = 16,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(NUM_REG - 1);

    logic [CNT_W-1:0] cnt_reg;

    // Counter state: clear has priority, increment stops at the terminal value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != LAST_VAL)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt  = cnt_reg;
    assign last = (cnt_reg == LAST_VAL);

endmodule

// File: rtl/reg_seq_ctrl.sv
// Command sequencer driving the reg_file control inputs.
// Accepts one command over valid/ready, expands it into reg_file
// write/select cycles and returns a single-cycle response.
// Optional feature macro: REG_SEQ_SWAP_EN (SWP command; otherwise SWP is illegal).
module reg_seq_ctrl
    import reg_seq_pkg::*;
#(
    parameter int REG_WIDTH   = 8,
    parameter int REG_POINTER = 4,
    parameter int NUM_REG     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [REG_POINTER-1:0] cmd_addr,
    input  logic [REG_WIDTH-1:0]   cmd_data,
    output logic                   rsp_valid,
    output logic [REG_WIDTH-1:0]   rsp_data,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   rf_reg_write,
    output logic                   rf_acc_write,
    output logic [REG_WIDTH-1:0]   rf_value_in,
    output logic [REG_POINTER-1:0] rf_reg_addr,
    input  logic [REG_WIDTH-1:0]   rf_reg_out,
    input  logic [REG_WIDTH-1:0]   rf_acc_out
);

    state_e                 state_reg;
    state_e                 state_next;
    logic [2:0]             op_reg;
    logic [REG_POINTER-1:0] addr_reg;
    logic [REG_WIDTH-1:0]   data_reg;
    logic [REG_WIDTH-1:0]   cap_reg;
`ifdef REG_SEQ_SWAP_EN
    logic [REG_WIDTH-1:0]   tmp_reg;
`endif

    logic                   accept;
    logic                   sweep_clr;
    logic                   sweep_inc;
    logic [REG_POINTER-1:0] sweep_cnt;
    logic                   sweep_last;

    assign accept    = (state_reg == ST_IDLE) && cmd_valid;
    assign sweep_clr = (state_reg == ST_CLR_Z);
    assign sweep_inc = (state_reg == ST_CLR_S);

    reg_seq_sweep_cnt #(
        .NUM_REG (NUM_REG),
        .CNT_W   (REG_POINTER)
    ) u_sweep_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (sweep_clr),
        .inc   (sweep_inc),
        .cnt   (sweep_cnt),
        .last  (sweep_last)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Command capture on acceptance; command inputs are ignored at all other times.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg   <= '0;
            addr_reg <= '0;
            data_reg <= '0;
        end else if (accept) begin
            op_reg   <= cmd_op;
            addr_reg <= cmd_addr;
            data_reg <= cmd_data;
        end
    end

    // Result capture in EXEC: accumulator for STA, addressed register for RDR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_reg <= '0;
        end else if (state_reg == ST_EXEC) begin
            cap_reg <= (op_reg == OP_STA) ? rf_acc_out : rf_reg_out;
        end
    end

`ifdef REG_SEQ_SWAP_EN
    // Old register value for SWP, captured on the same edge the accumulator overwrites it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmp_reg <= '0;
        end else if ((state_reg == ST_EXEC) && (op_reg == OP_SWP)) begin
            tmp_reg <= rf_reg_out;
        end
    end
`endif

    // Next-state decode.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_next = (cmd_op == OP_CLR) ? ST_CLR_Z : ST_EXEC;
                end
            end
            ST_EXEC: begin
`ifdef REG_SEQ_SWAP_EN
                state_next = (op_reg == OP_SWP) ? ST_SWP_A : ST_DONE;
`else
                state_next = ST_DONE;
`endif
            end
`ifdef REG_SEQ_SWAP_EN
            ST_SWP_A: state_next = ST_DONE;
`endif
            ST_CLR_Z: state_next = ST_CLR_S;
            ST_CLR_S: begin
                if (sweep_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Handshake and response outputs; response data is forced to 0 outside DONE.
    always_comb begin
        cmd_ready = (state_reg == ST_IDLE);
        busy      = (state_reg != ST_IDLE);
        rsp_valid = (state_reg == ST_DONE);
        rsp_err   = 1'b0;
        rsp_data  = '0;
        if (state_reg == ST_DONE) begin
            rsp_err = !op_legal(op_reg);
            case (op_reg)
                OP_LDA:         rsp_data = data_reg;
                OP_STA, OP_RDR: rsp_data = cap_reg;
`ifdef REG_SEQ_SWAP_EN
                OP_SWP:         rsp_data = tmp_reg;
`endif
                default:        rsp_data = '0;
            endcase
        end
    end

    // reg_file control decode from registered state only; the two write
    // strobes are never raised together.
    always_comb begin
        rf_reg_write = 1'b0;
        rf_acc_write = 1'b0;
        rf_value_in  = '0;
        rf_reg_addr  = '0;
        case (state_reg)
            ST_EXEC: begin
                case (op_reg)
                    OP_LDA: begin
                        rf_acc_write = 1'b1;
                        rf_value_in  = data_reg;
                    end
                    OP_STA: begin
                        rf_reg_write = 1'b1;
                        rf_reg_addr  = addr_reg;
                        rf_value_in  = rf_acc_out;
                    end
                    OP_RDR: begin
                        rf_reg_addr  = addr_reg;
                    end
`ifdef REG_SEQ_SWAP_EN
                    OP_SWP: begin
                        rf_reg_write = 1'b1;
                        rf_reg_addr  = addr_reg;
                        rf_value_in  = rf_acc_out;
                    end
`endif
                    default: begin
                        rf_reg_write = 1'b0;
                    end
                endcase
            end
`ifdef REG_SEQ_SWAP_EN
            ST_SWP_A: begin
                rf_acc_write = 1'b1;
                rf_value_in  = tmp_reg;
            end
`endif
            ST_CLR_Z: begin
                rf_acc_write = 1'b1;
                rf_value_in  = '0;
            end
            ST_CLR_S: begin
                rf_reg_write = 1'b1;
                rf_reg_addr  = sweep_cnt;
                rf_value_in  = '0;
            end
            default: begin
                rf_reg_write = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Directed testbench for reg_seq_ctrl with a behavioural reg_file model.
// Honours REG_SEQ_SWAP_EN to pick the expected SWP behaviour.
module tb_reg_seq_ctrl;
    import reg_seq_pkg::*;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;
    logic       rf_reg_write;
    logic       rf_acc_write;
    logic [7:0] rf_value_in;
    logic [3:0] rf_reg_addr;
    logic [7:0] rf_reg_out;
    logic [7:0] rf_acc_out;

    int total = 0;
    int bad   = 0;

    reg_seq_ctrl #(.REG_WIDTH(8), .REG_POINTER(4), .NUM_REG(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .rf_reg_write (rf_reg_write),
        .rf_acc_write (rf_acc_write),
        .rf_value_in  (rf_value_in),
        .rf_reg_addr  (rf_reg_addr),
        .rf_reg_out   (rf_reg_out),
        .rf_acc_out   (rf_acc_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reg_file model: reg_write wins over acc_write, combinational register read.
    logic [7:0] mregs [16];
    logic [7:0] macc;
    always @(posedge clk) begin
        if (rf_reg_write) mregs[rf_reg_addr] <= rf_value_in;
        else if (rf_acc_write) macc <= rf_value_in;
    end
    assign rf_reg_out = mregs[rf_reg_addr];
    assign rf_acc_out = macc;

    typedef struct packed {
        logic       is_reg;
        logic [3:0] addr;
        logic [7:0] val;
    } wr_t;

    wr_t wlog[$];
    int  both_cnt;
    int  nz_idle;

    // Issue one command, log reg_file writes and wait (bounded) for the response.
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] addr, input logic [7:0] data,
                           output int lat, output logic [7:0] rdata, output logic rerr);
        wr_t w;
        wlog.delete();
        both_cnt = 0;
        nz_idle  = 0;
        lat      = -1;
        rdata    = '0;
        rerr     = 1'b0;
        @(negedge clk);
        cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (rf_reg_write && rf_acc_write) both_cnt++;
            if (rf_reg_write || rf_acc_write) begin
                w.is_reg = rf_reg_write;
                w.addr   = rf_reg_write ? rf_reg_addr : 4'd0;
                w.val    = rf_value_in;
                wlog.push_back(w);
            end
            if (rsp_valid) begin
                lat = k; rdata = rsp_data; rerr = rsp_err;
                break;
            end
            if (rsp_data !== 8'h00) nz_idle++;
            @(negedge clk);
        end
        total++;
        if (lat < 0) begin
            bad++;
            $display("FAIL rsp_timeout op=%0d: no rsp_valid within 40 cycles, required one", op);
        end
        $display("cmd op=%0d addr=%0d data=%h -> lat=%0d rsp_data=%h rsp_err=%b writes=%0d",
                 op, addr, data, lat, rdata, rerr, wlog.size());
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({cmd_ready, busy} !== 2'b10) begin
            bad++; $display("FAIL reset_hs: ready,busy=%b required 10", {cmd_ready, busy});
        end
        total++;
        if ({rsp_valid, rsp_err, rsp_data} !== 10'd0) begin
            bad++; $display("FAIL reset_rsp: valid,err,data=%h required 0", {rsp_valid, rsp_err, rsp_data});
        end
        total++;
        if ({rf_reg_write, rf_acc_write, rf_value_in, rf_reg_addr} !== 14'd0) begin
            bad++; $display("FAIL reset_rf: rf outputs=%h required 0",
                            {rf_reg_write, rf_acc_write, rf_value_in, rf_reg_addr});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lda();
        int lat; logic [7:0] d; logic e; logic ok;
        run_cmd(3'd0, 4'd0, 8'hA5, lat, d, e);
        total++;
        if (lat !== RSP_LAT_SIMPLE) begin bad++; $display("FAIL lda_lat: got %0d required 2", lat); end
        total++;
        if ({e, d} !== {1'b0, 8'hA5}) begin bad++; $display("FAIL lda_rsp: err,data=%b,%h required 0,a5", e, d); end
        ok = (wlog.size() == 1) && !wlog[0].is_reg && (wlog[0].val == 8'hA5);
        total++;
        if (!ok) begin bad++; $display("FAIL lda_writes: count=%0d required one acc write of a5", wlog.size()); end
        total++;
        if (macc !== 8'hA5) begin bad++; $display("FAIL lda_acc: model acc=%h required a5", macc); end
        total++;
        if (nz_idle !== 0) begin bad++; $display("FAIL lda_idle_data: nonzero rsp_data cycles=%0d required 0", nz_idle); end
    endtask

    task automatic test_sta_rdr();
        int lat; logic [7:0] d; logic e; logic ok;
        run_cmd(3'd0, 4'd0, 8'h3C, lat, d, e);
        run_cmd(3'd1, 4'd7, 8'h00, lat, d, e);
        total++;
        if ({lat, e, d} !== {32'd2, 1'b0, 8'h3C}) begin
            bad++; $display("FAIL sta_rsp: lat=%0d err=%b data=%h required 2,0,3c", lat, e, d);
        end
        ok = (wlog.size() == 1) && wlog[0].is_reg && (wlog[0].addr == 4'd7) && (wlog[0].val == 8'h3C);
        total++;
        if (!ok) begin bad++; $display("FAIL sta_writes: count=%0d required one reg write 7<=3c", wlog.size()); end
        run_cmd(3'd2, 4'd7, 8'h00, lat, d, e);
        total++;
        if ({lat, e, d} !== {32'd2, 1'b0, 8'h3C}) begin
            bad++; $display("FAIL rdr_rsp: lat=%0d err=%b data=%h required 2,0,3c", lat, e, d);
        end
        total++;
        if (wlog.size() !== 0) begin bad++; $display("FAIL rdr_writes: count=%0d required 0", wlog.size()); end
        total++;
        if (mregs[7] !== 8'h3C) begin bad++; $display("FAIL sta_reg7: model reg7=%h required 3c", mregs[7]); end
    endtask

    task automatic test_swp();
        int lat; logic [7:0] d; logic e;
        run_cmd(3'd0, 4'd0, 8'h11, lat, d, e);
        run_cmd(3'd1, 4'd3, 8'h00, lat, d, e);
        run_cmd(3'd0, 4'd0, 8'h22, lat, d, e);
        run_cmd(3'd3, 4'd3, 8'h00, lat, d, e);
`ifdef REG_SEQ_SWAP_EN
        total++;
        if ({lat, e, d} !== {32'd3, 1'b0, 8'h11}) begin
            bad++; $display("FAIL swp_rsp: lat=%0d err=%b data=%h required 3,0,11", lat, e, d);
        end
        total++;
        if ({mregs[3], macc} !== {8'h22, 8'h11}) begin
            bad++; $display("FAIL swp_state: reg3=%h acc=%h required 22,11", mregs[3], macc);
        end
`else
        total++;
        if ({lat, e, d} !== {32'd2, 1'b1, 8'h00}) begin
            bad++; $display("FAIL swp_rsp: lat=%0d err=%b data=%h required 2,1,00", lat, e, d);
        end
        total++;
        if ({mregs[3], macc, 32'(wlog.size())} !== {8'h11, 8'h22, 32'd0}) begin
            bad++; $display("FAIL swp_state: reg3=%h acc=%h writes=%0d required 11,22,0", mregs[3], macc, wlog.size());
        end
`endif
    endtask

    task automatic test_clr();
        int lat; logic [7:0] d; logic e; int order_bad; int nz;
        run_cmd(3'd0, 4'd0, 8'h5A, lat, d, e);
        run_cmd(3'd1, 4'd15, 8'h00, lat, d, e);
        run_cmd(3'd1, 4'd0, 8'h00, lat, d, e);
        run_cmd(3'd0, 4'd0, 8'h33, lat, d, e);
        run_cmd(3'd4, 4'd9, 8'hFF, lat, d, e);
        total++;
        if ({lat, e, d} !== {32'd18, 1'b0, 8'h00}) begin
            bad++; $display("FAIL clr_rsp: lat=%0d err=%b data=%h required 18,0,00", lat, e, d);
        end
        order_bad = 0;
        if (wlog.size() != 17) order_bad++;
        else begin
            if (wlog[0].is_reg || wlog[0].val != 8'h00) order_bad++;
            for (int i = 1; i < 17; i++)
                if (!wlog[i].is_reg || wlog[i].addr != 4'(i - 1) || wlog[i].val != 8'h00) order_bad++;
        end
        total++;
        if (order_bad !== 0) begin
            bad++; $display("FAIL clr_order: writes=%0d bad_entries=%0d required 17,0", wlog.size(), order_bad);
        end
        total++;
        if (both_cnt !== 0) begin bad++; $display("FAIL clr_both_write: cycles=%0d required 0", both_cnt); end
        nz = 0;
        for (int i = 0; i < 16; i++) if (mregs[i] !== 8'h00) nz++;
        total++;
        if ({32'(nz), macc} !== {32'd0, 8'h00}) begin
            bad++; $display("FAIL clr_regs: nonzero regs=%0d acc=%h required 0,00", nz, macc);
        end
    endtask

    task automatic test_illegal();
        int lat; logic [7:0] d; logic e;
        run_cmd(3'd6, 4'd2, 8'h44, lat, d, e);
        total++;
        if ({lat, e, d} !== {32'd2, 1'b1, 8'h00}) begin
            bad++; $display("FAIL ill6_rsp: lat=%0d err=%b data=%h required 2,1,00", lat, e, d);
        end
        total++;
        if (wlog.size() !== 0) begin bad++; $display("FAIL ill6_writes: count=%0d required 0", wlog.size()); end
        run_cmd(3'd5, 4'd1, 8'h00, lat, d, e);
        total++;
        if ({lat, e, wlog.size()} !== {32'd2, 1'b1, 32'd0}) begin
            bad++; $display("FAIL ill5_rsp: lat=%0d err=%b writes=%0d required 2,1,0", lat, e, wlog.size());
        end
    endtask

    task automatic test_back_to_back();
        int clr_k, lda_k, ready_bad;
        logic ready19; logic [7:0] lda_d;
        clr_k = -1; lda_k = -1; ready_bad = 0; ready19 = 1'b0; lda_d = '0;
        @(negedge clk);
        cmd_op = 3'd4; cmd_addr = 4'd0; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_op = 3'd0; cmd_data = 8'h77;
        for (int k = 1; k <= 40; k++) begin
            if (k <= 18 && cmd_ready !== 1'b0) ready_bad++;
            if (k == 19) ready19 = cmd_ready;
            if (rsp_valid) begin
                if (clr_k < 0) clr_k = k;
                else begin lda_k = k; lda_d = rsp_data; break; end
            end
            if (k == 20) cmd_valid = 1'b0;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        $display("b2b CLR rsp at %0d, held LDA rsp at %0d data=%h", clr_k, lda_k, lda_d);
        total++;
        if (clr_k !== 18) begin bad++; $display("FAIL b2b_clr_lat: got %0d required 18", clr_k); end
        total++;
        if (ready_bad !== 0) begin bad++; $display("FAIL b2b_ready_busy: ready high cycles=%0d required 0", ready_bad); end
        total++;
        if (ready19 !== 1'b1) begin bad++; $display("FAIL b2b_ready_idle: got %b required 1", ready19); end
        total++;
        if ({lda_k, lda_d} !== {32'd21, 8'h77}) begin
            bad++; $display("FAIL b2b_lda: at=%0d data=%h required 21,77", lda_k, lda_d);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat; logic [7:0] d; logic e; logic [7:0] exp;
        run_cmd(3'd0, 4'd0, 8'h99, lat, d, e);
        for (int a = 0; a < 16; a++) run_cmd(3'd1, 4'(a), 8'h00, lat, d, e);
        @(negedge clk);
        cmd_op = 3'd4; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if ({rf_reg_write, rf_reg_addr} !== {1'b1, 4'd5}) begin
            bad++; $display("FAIL mid_pre: reg_write,addr=%b,%0d required 1,5", rf_reg_write, rf_reg_addr);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({rf_reg_write, rf_acc_write, rf_value_in, rf_reg_addr} !== 14'd0) begin
            bad++; $display("FAIL mid_rf: rf outputs=%h required 0",
                            {rf_reg_write, rf_acc_write, rf_value_in, rf_reg_addr});
        end
        total++;
        if ({busy, cmd_ready, rsp_valid} !== 3'b010) begin
            bad++; $display("FAIL mid_hs: busy,ready,rsp=%b required 010", {busy, cmd_ready, rsp_valid});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp = (i < 5) ? 8'h00 : 8'h99;
            total++;
            if (mregs[i] !== exp) begin
                bad++; $display("FAIL mid_reg%0d: got %h required %h", i, mregs[i], exp);
            end
        end
        run_cmd(3'd0, 4'd0, 8'h5C, lat, d, e);
        total++;
        if ({lat, e, d} !== {32'd2, 1'b0, 8'h5C}) begin
            bad++; $display("FAIL mid_recover: lat=%0d err=%b data=%h required 2,0,5c", lat, e, d);
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_sta_rdr();
        test_swp();
        test_clr();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
